booth_r4_seq_mul: RTL and testbench
===================================

Name: booth_r4_seq_mul

Overview:
- Parametrised sequential radix-4 Booth multiplier.
- Successor to the fixed 8-bit radix-2 shift-add multiplier.
- Adds a run-time signed/unsigned mode, a start/done handshake, back-to-back operation, and roughly half the latency.
- Used as a shared, low-area multiply resource beside datapath blocks that tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4. The product is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when in_ready=1
- is_signed  in  1  1: a, b are two's complement; 0: unsigned. Latched with start.
- a  in  WIDTH  multiplicand, latched on the start-accept edge
- b  in  WIDTH  multiplier, latched on the start-accept edge
- in_ready  out  1  high in IDLE and DONE
- busy  out  1  high in CALC
- done  out  1  one-cycle pulse; p valid
- p  out  2*WIDTH  product; holds its value until the next done

Behaviour:
- Reset: reset is asynchronous and active-low; clock is clk. While reset=0:
  - state=IDLE, busy=0, done=0, p=0, in_ready=1;
  - internal accumulator, operand and counter registers are cleared.
- Reset mid-operation aborts the operation immediately; no done is produced.
- Operand extension on accept: the latched multiplier M and multiplicand D are extended to WIDTH+2 bits.
  - is_signed=1: sign-extend.
  - is_signed=0: zero-extend.
  - The extended width is even, so unsigned operands need no special case.
- Iterations: N = WIDTH/2 + 1, one per clock in CALC. Iteration i uses digit {M[2i+1], M[2i], M[2i-1]}, with M[-1]=0. Booth encoding:
  - 000 / 111 -> 0
  - 001 / 010 -> +D
  - 011 -> +2D
  - 100 -> -2D
  - 101 / 110 -> -D
- The partial product is shifted left 2i and added into a 2*WIDTH+4-bit accumulator. p takes the low 2*WIDTH bits; this is exact for both modes.
- FSM:
  - IDLE: start=1 -> CALC; latch operands, ctr=0, acc=0.
  - CALC: ctr increments each cycle. On ctr=N-1 the final add is performed -> DONE, and p is loaded from the accumulator on the same edge.
  - DONE: done=1 for this cycle only. start=1 -> CALC with new operands (back-to-back). Otherwise -> IDLE.
- Latency: done is high in the cycle that begins N clock edges after the accept edge. For WIDTH=8 that is 5 edges; issue interval is 6 cycles back-to-back.
- start while busy=1 is ignored. No queueing and no error flag.
- p changes only on the edge entering DONE (or on reset). It is stable for the whole of IDLE.
- a, b and is_signed may change freely after the accept edge.

Optional Feature:
- Macro: MUL_ACC_EN.
- Defined:
  - Adds input port acc_clr (1 bit), latched with start.
  - On completion, p <= (acc_clr ? 0 : p) + a*b, modulo 2^(2*WIDTH); wrap-around is silent.
  - Reset still clears p.
- Undefined:
  - No acc_clr port.
  - p <= a*b on each completion.

Decomposition:
- Package booth_mul_pkg:
  - FSM state enum (IDLE, CALC, DONE);
  - Booth digit typedef (3-bit select, neg, x2);
  - a function returning N from WIDTH.
- One natural sub-module, booth_r4_enc: combinational. Takes a 3-bit digit and the extended multiplicand; returns the signed partial product (WIDTH+3 bits, sign-extended by the caller).
- Counter, FSM and accumulator stay in the top module.

Test Plan:
- WIDTH=8, is_signed=0, a=255, b=255 -> done 5 edges after accept; p=16'hFE01.
- WIDTH=8, is_signed=1:
  - a=-128, b=-128 -> p=16'h4000;
  - a=-128, b=127 -> p=16'hC080;
  - a=0, b=-1 -> p=0.
- Back-to-back: start held high through DONE, pairs (3,5) then (-7,9) signed -> done pulses 6 cycles apart; p=15 then p=16'hFFC1.
- start asserted during CALC with different operands -> ignored; result matches the first operands; exactly one done.
- reset driven low at CALC cycle 2, released, then new start with a=12, b=10 unsigned -> no done from the aborted operation; p=0 until the new done; then p=120.
- MUL_ACC_EN defined:
  - acc_clr=1, (10,10) -> p=100;
  - acc_clr=0, (20,20) -> p=500;
  - acc_clr=0, repeat 255x255 unsigned -> p wraps modulo 2^16.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t     : FSM states (IDLE, CALC, DONE)
//   booth_dig_t : decoded Booth digit (raw 3-bit select, negate, double, zero)
//   booth_iters : number of radix-4 iterations for a given operand width
package booth_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] sel;   // {M[2i+1], M[2i], M[2i-1]}
    logic       neg;   // subtract the multiple
    logic       x2;    // use 2*D instead of D
    logic       zero;  // digit contributes nothing
  } booth_dig_t;

  // Operands are extended to WIDTH+2 bits, giving (WIDTH+2)/2 radix-4 digits.
  function automatic int unsigned booth_iters(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic booth_dig_t booth_decode(input logic [2:0] sel);
    booth_dig_t r;
    r.sel  = sel;
    r.neg  = 1'b0;
    r.x2   = 1'b0;
    r.zero = 1'b0;
    case (sel)
      3'b000, 3'b111: r.zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         r.x2 = 1'b1;
      3'b100: begin
        r.neg = 1'b1;
        r.x2  = 1'b1;
      end
      default:        r.neg = 1'b1;   // 101, 110
    endcase
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product generator (purely combinational).
// Ports:
//   digit : 3-bit Booth digit {M[2i+1], M[2i], M[2i-1]}
//   d     : multiplicand, already extended to WIDTH+2 bits
//   pp    : signed partial product, WIDTH+3 bits (0, +-D or +-2D)
module booth_r4_enc
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH+1:0] d,
  output logic [WIDTH+2:0] pp
);

  booth_dig_t       dec;
  logic [WIDTH+2:0] mag;

  always_comb begin
    dec = booth_decode(digit);
    // One extra bit holds 2*D without overflow for either operand mode.
    mag = {d[WIDTH+1], d};
    if (dec.x2) begin
      mag = {d, 1'b0};
    end
    pp = '0;
    if (!dec.zero) begin
      pp = dec.neg ? (~mag + 1'b1) : mag;
    end
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   start           : request, accepted only while in_ready=1
//   is_signed       : operands are two's complement (1) or unsigned (0)
//   a, b            : multiplicand / multiplier, latched on accept
//   acc_clr         : (MUL_ACC_EN only) clear p before accumulating
//   in_ready        : high in IDLE and DONE
//   busy            : high in CALC
//   done            : one-cycle pulse, p valid
//   p               : 2*WIDTH-bit product, held until the next done
// Build option: define MUL_ACC_EN to make p accumulate products
// (p <= (acc_clr ? 0 : p) + a*b, wrapping modulo 2^(2*WIDTH)).
module booth_r4_seq_mul
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_ACC_EN
  input  logic               acc_clr,
`endif
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int XW = WIDTH + 2;         // extended operand width
  localparam int AW = 2 * WIDTH + 4;     // accumulator width
  localparam int N  = booth_iters(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t             state_q, state_d;
  logic [XW:0]        m_q, m_d;          // {multiplier, M[-1]} shifted right 2 per step
  logic [XW-1:0]      d_q, d_d;
  logic [CW-1:0]      ctr_q, ctr_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
`ifdef MUL_ACC_EN
  logic               acc_clr_q, acc_clr_d;
`endif

  logic [WIDTH+2:0]   pp;
  logic [AW-1:0]      pp_ext;
  logic [AW-1:0]      acc_sum;
  logic               accept;

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .digit (m_q[2:0]),
    .d     (d_q),
    .pp    (pp)
  );

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy     = (state_q == ST_CALC);
  assign done     = (state_q == ST_DONE);
  assign p        = p_q;
  assign accept   = in_ready && start;

  // Sign-extend the partial product and place it at weight 4^i.
  assign pp_ext  = {{(AW - (WIDTH + 3)){pp[WIDTH+2]}}, pp};
  assign acc_sum = acc_q + (pp_ext << {ctr_q, 1'b0});

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    d_d     = d_q;
    ctr_d   = ctr_q;
    acc_d   = acc_q;
    p_d     = p_q;
`ifdef MUL_ACC_EN
    acc_clr_d = acc_clr_q;
`endif
    case (state_q)
      ST_CALC: begin
        acc_d = acc_sum;
        // Consumed digits fall off the bottom; the top is never read again.
        m_d   = {2'b00, m_q[XW:2]};
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == LAST) begin
          state_d = ST_DONE;
`ifdef MUL_ACC_EN
          p_d = (acc_clr_q ? '0 : p_q) + acc_sum[2*WIDTH-1:0];
`else
          p_d = acc_sum[2*WIDTH-1:0];
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept overrides the IDLE/DONE transitions above (back-to-back).
    if (accept) begin
      state_d = ST_CALC;
      m_d     = {(is_signed ? {2{b[WIDTH-1]}} : 2'b00), b, 1'b0};
      d_d     = {(is_signed ? {2{a[WIDTH-1]}} : 2'b00), a};
      ctr_d   = '0;
      acc_d   = '0;
`ifdef MUL_ACC_EN
      acc_clr_d = acc_clr;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      d_q     <= '0;
      ctr_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
`ifdef MUL_ACC_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      d_q     <= d_d;
      ctr_q   <= ctr_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
`ifdef MUL_ACC_EN
      acc_clr_q <= acc_clr_d;
`endif
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed-vector bench for booth_r4_seq_mul (WIDTH=8).
module tb_booth_r4_seq_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        acc_clr;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mul #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
`ifdef MUL_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .p         (p)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One multiply: accept, wait for done, check latency, result, p hold, pulse width.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input logic tclr, input logic [15:0] exp, input string tag);
    int          lat;
    int          w;
    logic [15:0] p0;
    logic        held;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    a = ta; b = tb_v; is_signed = ts; acc_clr = tclr; start = 1'b1;
    p0 = p;
    held = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    is_signed = ~ts;
    acc_clr = ~tclr;
    lat = 99;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        break;
      end
      if (p !== p0) held = 1'b0;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'd5);
    check_val({tag, "_p"}, 32'(p), 32'(exp));
    check_val({tag, "_hold"}, 32'(held), 32'd1);
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, 32'(done), 32'd0);
    $display("op %s a=%0h b=%0h signed=%0d clr=%0d lat=%0d p=%0h exp=%0h",
             tag, ta, tb_v, ts, tclr, lat, p, exp);
  endtask

  initial begin
    int          t1;
    int          t2;
    int          ndone;
    logic [15:0] pa;
    logic [15:0] pb;

    reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; acc_clr = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd1);
    check_val("rst_p", 32'(p), 32'd0);
    reset = 1'b1;

    // Basic vectors
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, "u255x255");
    run_op(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, "sm128xm128");
    run_op(8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080, "sm128x127");
    run_op(8'h00, 8'hFF, 1'b1, 1'b1, 16'h0000, "s0xm1");
    run_op(8'hC8, 8'h03, 1'b0, 1'b1, 16'h0258, "u200x3");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001, "sm1xm1");

    // Back-to-back: start held through DONE
    @(negedge clk);
    a = 8'd3; b = 8'd5; is_signed = 1'b1; acc_clr = 1'b1; start = 1'b1;
    t1 = -1; t2 = -1; pa = '0; pb = '0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (done && t1 < 0) begin
        t1 = e;
        pa = p;
        @(negedge clk);
        a = 8'hF9; b = 8'd9;
      end else if (done && t1 >= 0) begin
        t2 = e;
        pb = p;
        break;
      end else if (t1 >= 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_val("b2b_p1", 32'(pa), 32'd15);
    check_val("b2b_p2", 32'(pb), 32'h0000FFC1);
    check_val("b2b_gap", 32'(t2 - t1), 32'd6);
    $display("op b2b p1=%0h p2=%0h gap=%0d", pa, pb, t2 - t1);
    @(posedge clk);

    // start during CALC must be ignored
    @(negedge clk);
    a = 8'd6; b = 8'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    check_val("ign_busy", 32'(busy), 32'd1);
    @(negedge clk);
    a = 8'd100; b = 8'd100;
    repeat (3) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    pa = '0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        pa = p;
      end
    end
    check_val("ign_p", 32'(pa), 32'd42);
    check_val("ign_ndone", 32'(ndone), 32'd1);
    $display("op ignore p=%0h dones=%0d", pa, ndone);

    // Reset mid-operation
    @(negedge clk);
    a = 8'd50; b = 8'd50; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("abort_p", 32'(p), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    pa = '0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      pa = pa | p;
    end
    check_val("abort_nodone", 32'(ndone), 32'd0);
    check_val("abort_p_zero", 32'(pa), 32'd0);
    $display("op abort dones=%0d p=%0h", ndone, pa);
    run_op(8'd12, 8'd10, 1'b0, 1'b1, 16'd120, "u12x10");

`ifdef MUL_ACC_EN
    run_op(8'd10, 8'd10, 1'b0, 1'b1, 16'd100, "acc_clr10");
    run_op(8'd20, 8'd20, 1'b0, 1'b0, 16'd500, "acc20");
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFFF5, "acc255a");
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFDF6, "acc255wrap");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
